// File: rtl/tl_run_ctrl_if.sv
// TileLink-UL A/D channel bundle for the run-control slave.
// The master drives the A channel and accepts D; the slave is the reverse.
interface tl_run_ctrl_if #(
    parameter int XLEN      = 32,
    parameter int SID_WIDTH = 2
);
    // A channel
    logic                   tl_a_valid;
    logic                   tl_a_ready;
    logic [2:0]             tl_a_opcode;
    logic [2:0]             tl_a_param;
    logic [2:0]             tl_a_size;
    logic [SID_WIDTH-1:0]   tl_a_source;
    logic [XLEN-1:0]        tl_a_address;
    logic [XLEN/8-1:0]      tl_a_mask;
    logic [XLEN-1:0]        tl_a_data;

    // D channel
    logic                   tl_d_valid;
    logic                   tl_d_ready;
    logic [2:0]             tl_d_opcode;
    logic [1:0]             tl_d_param;
    logic [2:0]             tl_d_size;
    logic [SID_WIDTH-1:0]   tl_d_source;
    logic [XLEN-1:0]        tl_d_data;
    logic                   tl_d_corrupt;
    logic                   tl_d_denied;

    modport master (
        output tl_a_valid, tl_a_opcode, tl_a_param, tl_a_size, tl_a_source,
               tl_a_address, tl_a_mask, tl_a_data,
        input  tl_a_ready,
        input  tl_d_valid, tl_d_opcode, tl_d_param, tl_d_size, tl_d_source,
               tl_d_data, tl_d_corrupt, tl_d_denied,
        output tl_d_ready
    );

    modport slave (
        input  tl_a_valid, tl_a_opcode, tl_a_param, tl_a_size, tl_a_source,
               tl_a_address, tl_a_mask, tl_a_data,
        output tl_a_ready,
        output tl_d_valid, tl_d_opcode, tl_d_param, tl_d_size, tl_d_source,
               tl_d_data, tl_d_corrupt, tl_d_denied,
        input  tl_d_ready
    );
endinterface

// File: rtl/tl_run_ctrl.sv
// Run supervisor: counts run cycles, detects exit/trap/halt/watchdog stop
// events, latches the stop cause and exposes it on ports and on a small
// TileLink-UL register file (one outstanding request).
module tl_run_ctrl #(
    parameter int          XLEN         = 32,
    parameter int          SID_WIDTH    = 2,
    parameter int          NUM_HARTS    = 1,
    parameter int          CNT_WIDTH    = 64,
    parameter logic [63:0] TIMEOUT_INIT = 64'd0
) (
    input  logic                  clk,
    input  logic                  reset,
    tl_run_ctrl_if.slave          tl,
    input  logic                  run_en,
    input  logic [NUM_HARTS-1:0]  hart_halt,
    input  logic [NUM_HARTS-1:0]  hart_trap,
    output logic                  done,
    output logic                  pass,
    output logic [2:0]            stop_reason,
    output logic [3:0]            stop_hart,
    output logic [CNT_WIDTH-1:0]  cycle_count
);

    localparam int MW    = XLEN / 8;
    localparam int CMP_W = (CNT_WIDTH > XLEN) ? CNT_WIDTH : XLEN;

    localparam logic [2:0] OP_PUT_FULL = 3'd0;
    localparam logic [2:0] OP_PUT_PART = 3'd1;
    localparam logic [2:0] OP_GET      = 3'd4;
    localparam logic [2:0] D_ACK       = 3'd0;
    localparam logic [2:0] D_ACK_DATA  = 3'd1;

    localparam logic [4:0] REG_STATUS   = 5'h00;
    localparam logic [4:0] REG_EXIT     = 5'h04;
    localparam logic [4:0] REG_CYCLE_LO = 5'h08;
    localparam logic [4:0] REG_CYCLE_HI = 5'h0C;
    localparam logic [4:0] REG_TIMEOUT  = 5'h10;
    localparam logic [4:0] REG_SCRATCH  = 5'h14;

    localparam logic [2:0] RSN_NONE    = 3'd0;
    localparam logic [2:0] RSN_EXIT    = 3'd1;
    localparam logic [2:0] RSN_TRAP    = 3'd2;
    localparam logic [2:0] RSN_HALT    = 3'd3;
    localparam logic [2:0] RSN_TIMEOUT = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Byte-lane merge: lanes with a set mask bit take the new value.
    function automatic logic [XLEN-1:0] merge_bytes(
        input logic [XLEN-1:0] old_val,
        input logic [XLEN-1:0] new_val,
        input logic [MW-1:0]   byte_mask
    );
        logic [XLEN-1:0] r;
        r = old_val;
        for (int b = 0; b < MW; b++) begin
            if (byte_mask[b]) r[8*b +: 8] = new_val[8*b +: 8];
        end
        return r;
    endfunction

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [3:0] lowest_set(input logic [NUM_HARTS-1:0] v);
        logic [3:0] r;
        r = 4'd0;
        for (int i = NUM_HARTS - 1; i >= 0; i--) begin
            if (v[i]) r = 4'(i);
        end
        return r;
    endfunction

    state_t                state, state_next;
    logic [CNT_WIDTH-1:0]  cycle_q;
    logic [CNT_WIDTH-1:0]  cycle_inc;
    logic [63:0]           cycle_ext;
    logic [XLEN-1:0]       timeout_q;
    logic [XLEN-1:0]       scratch_q;
    logic [XLEN-2:0]       exit_code_q;
    logic [31:0]           cycle_hi_q;
    logic [2:0]            reason_q;
    logic [3:0]            hart_q;
    logic                  count_en;

    // A-channel decode
    logic                  a_fire;
    logic [4:0]            offset;
    logic                  is_get, is_put, bad_offset, req_denied;
    logic                  wr_ok, rd_ok;
    logic [XLEN-1:0]       exit_masked;
    logic [XLEN-1:0]       rd_data;
    logic [XLEN-1:0]       status_word;

    // Stop events
    logic                  exit_hit, trap_hit, halt_hit, timeout_hit, stop_hit;
    logic [2:0]            reason_next;
    logic [3:0]            hart_next;

    // D-channel response registers
    logic                  d_valid_q;
    logic [2:0]            d_opcode_q;
    logic [2:0]            d_size_q;
    logic [SID_WIDTH-1:0]  d_source_q;
    logic [XLEN-1:0]       d_data_q;
    logic                  d_denied_q;

    logic                  unused_ok;
    assign unused_ok = ^{tl.tl_a_param, tl.tl_a_address[XLEN-1:5]};

    assign cycle_ext = 64'(cycle_q);
    assign cycle_inc = cycle_q + CNT_WIDTH'(1);

    // Request decode: opcode class, offset legality and accepted read/write strobes.
    always_comb begin
        a_fire      = tl.tl_a_valid && tl.tl_a_ready;
        offset      = tl.tl_a_address[4:0];
        is_get      = (tl.tl_a_opcode == OP_GET);
        is_put      = (tl.tl_a_opcode == OP_PUT_FULL) || (tl.tl_a_opcode == OP_PUT_PART);
        bad_offset  = (offset[4:3] == 2'b11) || (offset[1:0] != 2'b00);
        req_denied  = !(is_get || is_put) || bad_offset;
        wr_ok       = a_fire && is_put && !req_denied;
        rd_ok       = a_fire && is_get && !req_denied;
        exit_masked = merge_bytes('0, tl.tl_a_data, tl.tl_a_mask);
    end

    // Read mux; the STATUS word carries the done state implicitly through stop_reason.
    always_comb begin
        status_word = {exit_code_q[XLEN-9:0], hart_q, 1'b0, reason_q};
        rd_data     = '0;
        case (offset)
            REG_STATUS:   rd_data = status_word;
            REG_CYCLE_LO: rd_data = XLEN'(cycle_ext);
            REG_CYCLE_HI: rd_data = (XLEN == 32) ? XLEN'(cycle_hi_q) : '0;
            REG_TIMEOUT:  rd_data = timeout_q;
            REG_SCRATCH:  rd_data = scratch_q;
            default:      rd_data = '0;
        endcase
    end

    // Stop-event detection with EXIT > TRAP > HALT > TIMEOUT priority.
    always_comb begin
        exit_hit    = (state == ST_RUN) && wr_ok && (offset == REG_EXIT) && exit_masked[0];
        trap_hit    = (state == ST_RUN) && (|hart_trap);
        halt_hit    = (state == ST_RUN) && (|hart_halt);
        timeout_hit = (state == ST_RUN) && (timeout_q != '0) &&
                      (CMP_W'(cycle_inc) >= CMP_W'(timeout_q));
        stop_hit    = exit_hit || trap_hit || halt_hit || timeout_hit;
        reason_next = RSN_NONE;
        hart_next   = 4'd0;
        if (exit_hit) begin
            reason_next = RSN_EXIT;
        end else if (trap_hit) begin
            reason_next = RSN_TRAP;
            hart_next   = lowest_set(hart_trap);
        end else if (halt_hit) begin
            reason_next = RSN_HALT;
            hart_next   = lowest_set(hart_halt);
        end else if (timeout_hit) begin
            reason_next = RSN_TIMEOUT;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    // FSM next state: DONE is left only through reset.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (run_en)   state_next = ST_RUN;
            ST_RUN:  if (stop_hit) state_next = ST_DONE;
            ST_DONE: state_next = ST_DONE;
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        count_en = (state == ST_RUN);
        done     = (state == ST_DONE);
        pass     = done && (reason_q == RSN_EXIT) && (exit_code_q == '0);
    end

    // Run cycle counter; counts every RUN cycle including the stopping one, then freezes.
    always_ff @(posedge clk) begin
        if (!reset)        cycle_q <= '0;
        else if (count_en) cycle_q <= cycle_inc;
    end

    // Latch the stop cause on the RUN -> DONE transition.
    always_ff @(posedge clk) begin
        if (!reset) begin
            reason_q <= RSN_NONE;
            hart_q   <= 4'd0;
        end else if (stop_hit) begin
            reason_q <= reason_next;
            hart_q   <= hart_next;
        end
    end

    // Writable registers and the CYCLE_HI read snapshot.
    always_ff @(posedge clk) begin
        if (!reset) begin
            timeout_q   <= XLEN'(TIMEOUT_INIT);
            scratch_q   <= '0;
            exit_code_q <= '0;
            cycle_hi_q  <= '0;
        end else begin
            if (wr_ok && offset == REG_TIMEOUT)
                timeout_q <= merge_bytes(timeout_q, tl.tl_a_data, tl.tl_a_mask);
            if (wr_ok && offset == REG_SCRATCH)
                scratch_q <= merge_bytes(scratch_q, tl.tl_a_data, tl.tl_a_mask);
            if (wr_ok && offset == REG_EXIT && state != ST_DONE)
                exit_code_q <= exit_masked[XLEN-1:1];
            if (rd_ok && offset == REG_CYCLE_LO)
                cycle_hi_q <= cycle_ext[63:32];
        end
    end

    // D-channel valid: set on A accept, cleared on D handshake; reset drops a pending beat.
    always_ff @(posedge clk) begin
        if (!reset)                         d_valid_q <= 1'b0;
        else if (a_fire)                    d_valid_q <= 1'b1;
        else if (d_valid_q && tl.tl_d_ready) d_valid_q <= 1'b0;
    end

    // D-channel payload, captured with the request and held until the handshake.
    always_ff @(posedge clk) begin
        if (a_fire) begin
            d_opcode_q <= is_get ? D_ACK_DATA : D_ACK;
            d_size_q   <= tl.tl_a_size;
            d_source_q <= tl.tl_a_source;
            d_denied_q <= req_denied;
            d_data_q   <= rd_ok ? rd_data : '0;
        end
    end

    assign tl.tl_a_ready   = !d_valid_q;
    assign tl.tl_d_valid   = d_valid_q;
    assign tl.tl_d_opcode  = d_opcode_q;
    assign tl.tl_d_param   = 2'b00;
    assign tl.tl_d_size    = d_size_q;
    assign tl.tl_d_source  = d_source_q;
    assign tl.tl_d_data    = d_data_q;
    assign tl.tl_d_corrupt = 1'b0;
    assign tl.tl_d_denied  = d_denied_q;

    assign stop_reason = reason_q;
    assign stop_hart   = hart_q;
    assign cycle_count = cycle_q;

endmodule

// File: tb/tb_tl_run_ctrl.sv
// Directed bench for tl_run_ctrl: stop causes, watchdog, register map and D-channel flow.
module tb_tl_run_ctrl;

    localparam int XLEN = 32;
    localparam int SID  = 2;
    localparam int NH   = 4;
    localparam int CW   = 64;

    localparam logic [2:0] OP_PUT_FULL = 3'd0;
    localparam logic [2:0] OP_PUT_PART = 3'd1;
    localparam logic [2:0] OP_GET      = 3'd4;
    localparam logic [2:0] OP_HINT     = 3'd5;

    logic           clk = 1'b0;
    logic           reset;
    logic           run_en;
    logic [NH-1:0]  hart_halt;
    logic [NH-1:0]  hart_trap;
    logic           done;
    logic           pass;
    logic [2:0]     stop_reason;
    logic [3:0]     stop_hart;
    logic [CW-1:0]  cycle_count;

    int             n_checks = 0;
    int             n_errors = 0;
    logic [SID-1:0] src_id   = '0;

    logic [2:0]     r_op;
    logic [31:0]    r_data;
    logic           r_den;

    always #5 clk = ~clk;

    tl_run_ctrl_if #(.XLEN(XLEN), .SID_WIDTH(SID)) bus ();

    tl_run_ctrl #(
        .XLEN(XLEN), .SID_WIDTH(SID), .NUM_HARTS(NH), .CNT_WIDTH(CW), .TIMEOUT_INIT(64'd0)
    ) dut (
        .clk(clk), .reset(reset), .tl(bus), .run_en(run_en),
        .hart_halt(hart_halt), .hart_trap(hart_trap),
        .done(done), .pass(pass), .stop_reason(stop_reason),
        .stop_hart(stop_hart), .cycle_count(cycle_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_idle();
        bus.tl_a_valid   = 1'b0;
        bus.tl_a_opcode  = 3'd0;
        bus.tl_a_param   = 3'd0;
        bus.tl_a_size    = 3'd2;
        bus.tl_a_source  = '0;
        bus.tl_a_address = '0;
        bus.tl_a_mask    = '0;
        bus.tl_a_data    = '0;
        bus.tl_d_ready   = 1'b0;
    endtask

    task automatic do_reset(input logic run);
        @(negedge clk);
        reset     = 1'b0;
        run_en    = run;
        hart_halt = '0;
        hart_trap = '0;
        bus_idle();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // One TileLink transaction; stall > 0 holds d_ready low that many cycles after D appears.
    task automatic tl_xfer(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] mask, input int stall,
                           output logic [2:0] d_op, output logic [31:0] d_dat, output logic d_den);
        int waited;
        logic [31:0] held;
        d_op  = 3'd7;
        d_dat = '0;
        d_den = 1'b0;
        src_id = src_id + 1'b1;
        @(negedge clk);
        bus.tl_a_valid   = 1'b1;
        bus.tl_a_opcode  = op;
        bus.tl_a_param   = 3'd0;
        bus.tl_a_size    = 3'd2;
        bus.tl_a_source  = src_id;
        bus.tl_a_address = addr;
        bus.tl_a_mask    = mask;
        bus.tl_a_data    = wdata;
        bus.tl_d_ready   = (stall == 0);
        waited = 0;
        while (!bus.tl_a_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.tl_a_ready) begin
            check("a_ready_timeout", 64'(bus.tl_a_ready), 64'd1);
            bus_idle();
            return;
        end
        @(posedge clk);
        #1 bus.tl_a_valid = 1'b0;
        @(negedge clk);
        check("d_valid_latency", 64'(bus.tl_d_valid), 64'd1);
        waited = 0;
        while (!bus.tl_d_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        d_op  = bus.tl_d_opcode;
        d_dat = bus.tl_d_data;
        d_den = bus.tl_d_denied;
        check("d_source_echo", 64'(bus.tl_d_source), 64'(src_id));
        check("d_size_echo", 64'(bus.tl_d_size), 64'd2);
        held = bus.tl_d_data;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("d_hold", {bus.tl_d_valid, bus.tl_a_ready, bus.tl_d_data},
                  {1'b1, 1'b0, held});
        end
        bus.tl_d_ready = 1'b1;
        @(posedge clk);
        #1 bus.tl_d_ready = 1'b0;
        @(negedge clk);
        check("d_release", {bus.tl_d_valid, bus.tl_a_ready}, 2'b01);
    endtask

    initial begin
        reset     = 1'b0;
        run_en    = 1'b0;
        hart_halt = '0;
        hart_trap = '0;
        bus_idle();
        do_reset(1'b0);

        // Reset state
        check("rst_done", 64'(done), 64'd0);
        check("rst_pass", 64'(pass), 64'd0);
        check("rst_reason", 64'(stop_reason), 64'd0);
        check("rst_hart", 64'(stop_hart), 64'd0);
        check("rst_count", cycle_count, 64'd0);
        check("rst_a_ready", 64'(bus.tl_a_ready), 64'd1);
        check("rst_d_valid", 64'(bus.tl_d_valid), 64'd0);
        repeat (5) @(negedge clk);
        check("idle_count", cycle_count, 64'd0);
        tl_xfer(OP_GET, 32'h10, 32'h0, 4'hF, 0, r_op, r_data, r_den);
        check("rst_timeout", 64'(r_data), 64'd0);
        tl_xfer(OP_GET, 32'h14, 32'h0, 4'hF, 0, r_op, r_data, r_den);
        check("rst_scratch", 64'(r_data), 64'd0);
        tl_xfer(OP_GET, 32'h00, 32'h0, 4'hF, 0, r_op, r_data, r_den);
        check("rst_status", 64'(r_data), 64'd0);

        // Halt on hart 0 while the counter reads 99 -> stops at 100
        run_en = 1'b1;
        for (int i = 0; i < 300 && cycle_count != 64'd99; i++) @(negedge clk);
        hart_halt = 4'b0001;
        @(negedge clk);
        check("halt_done", 64'(done), 64'd1);
        check("halt_reason", 64'(stop_reason), 64'd3);
        check("halt_hart", 64'(stop_hart), 64'd0);
        check("halt_count", cycle_count, 64'd100);
        check("halt_pass", 64'(pass), 64'd0);
        repeat (10) @(negedge clk);
        check("halt_frozen", cycle_count, 64'd100);
        hart_halt = '0;

        // Stalled read of CYCLE_LO, then the snapshot in CYCLE_HI
        tl_xfer(OP_GET, 32'h08, 32'h0, 4'hF, 5, r_op, r_data, r_den);
        check("cyc_lo_data", 64'(r_data), 64'd100);
        check("cyc_lo_opcode", 64'(r_op), 64'd1);
        check("cyc_lo_denied", 64'(r_den), 64'd0);
        tl_xfer(OP_GET, 32'h0C, 32'h0, 4'hF, 0, r_op, r_data, r_den);
        check("cyc_hi_data", 64'(r_data), 64'd0);
        tl_xfer(OP_GET, 32'h00, 32'h0, 4'hF, 0, r_op, r_data, r_den);
        check("halt_status", 64'(r_data), 64'h3);

        // Denied accesses and byte-masked writes
        tl_xfer(OP_GET, 32'h18, 32'h0, 4'hF, 0, r_op, r_data, r_den);
        check("bad_off_denied", 64'(r_den), 64'd1);
        check("bad_off_data", 64'(r_data), 64'd0);
        check("bad_off_opcode", 64'(r_op), 64'd1);
        tl_xfer(OP_PUT_FULL, 32'h14, 32'hA5A5A5A5, 4'hF, 0, r_op, r_data, r_den);
        check("scratch_wr_opcode", 64'(r_op), 64'd0);
        check("scratch_wr_denied", 64'(r_den), 64'd0);
        tl_xfer(OP_HINT, 32'h14, 32'h0, 4'hF, 0, r_op, r_data, r_den);
        check("hint_denied", 64'(r_den), 64'd1);
        tl_xfer(OP_PUT_PART, 32'h14, 32'h123456FF, 4'b0001, 0, r_op, r_data, r_den);
        check("partial_denied", 64'(r_den), 64'd0);
        tl_xfer(OP_GET, 32'h1000_0014, 32'h0, 4'hF, 0, r_op, r_data, r_den);
        check("scratch_merged", 64'(r_data), 64'hA5A5A5FF);
        tl_xfer(OP_GET, 32'h02, 32'h0, 4'hF, 0, r_op, r_data, r_den);
        check("misaligned_denied", 64'(r_den), 64'd1);
        tl_xfer(OP_GET, 32'h04, 32'h0, 4'hF, 0, r_op, r_data, r_den);
        check("exit_rd_zero", {r_den, r_data}, 33'h0);

        // Software exit with code 0, then with code 3
        do_reset(1'b1);
        tl_xfer(OP_PUT_FULL, 32'h04, 32'h1, 4'hF, 0, r_op, r_data, r_den);
        check("exit0_opcode", 64'(r_op), 64'd0);
        check("exit0_done", 64'(done), 64'd1);
        check("exit0_reason", 64'(stop_reason), 64'd1);
        check("exit0_pass", 64'(pass), 64'd1);
        do_reset(1'b1);
        tl_xfer(OP_PUT_FULL, 32'h04, 32'h7, 4'hF, 0, r_op, r_data, r_den);
        check("exit3_reason", 64'(stop_reason), 64'd1);
        check("exit3_pass", 64'(pass), 64'd0);
        tl_xfer(OP_GET, 32'h00, 32'h0, 4'hF, 0, r_op, r_data, r_den);
        check("exit3_status", 64'(r_data), 64'h301);

        // EXIT write in IDLE only records the code; events in IDLE are ignored
        do_reset(1'b0);
        tl_xfer(OP_PUT_FULL, 32'h04, 32'h5, 4'hF, 0, r_op, r_data, r_den);
        check("idle_exit_done", 64'(done), 64'd0);
        tl_xfer(OP_GET, 32'h00, 32'h0, 4'hF, 0, r_op, r_data, r_den);
        check("idle_exit_status", 64'(r_data), 64'h200);
        hart_halt = 4'b0001;
        hart_trap = 4'b0001;
        repeat (3) @(negedge clk);
        check("idle_events_ignored", {done, stop_reason}, 4'd0);
        hart_halt = '0;
        hart_trap = '0;

        // Watchdog at 50
        tl_xfer(OP_PUT_FULL, 32'h10, 32'd50, 4'hF, 0, r_op, r_data, r_den);
        tl_xfer(OP_GET, 32'h10, 32'h0, 4'hF, 0, r_op, r_data, r_den);
        check("timeout_rd", 64'(r_data), 64'd50);
        run_en = 1'b1;
        for (int i = 0; i < 200 && !done; i++) @(negedge clk);
        check("wdog_done", 64'(done), 64'd1);
        check("wdog_count", cycle_count, 64'd50);
        check("wdog_reason", 64'(stop_reason), 64'd4);

        // Watchdog disabled: still running after 10000 cycles
        do_reset(1'b1);
        repeat (10000) @(negedge clk);
        check("nowdog_running", 64'(done), 64'd0);
        check("nowdog_counted", 64'(cycle_count >= 64'd10000), 64'd1);

        // Trap beats halt; lowest trapping hart reported
        do_reset(1'b1);
        hart_trap = 4'b1100;
        hart_halt = 4'b0001;
        @(negedge clk);
        check("prio_reason", 64'(stop_reason), 64'd2);
        check("prio_hart", 64'(stop_hart), 64'd2);
        hart_trap = '0;
        hart_halt = '0;

        // Lowest halting hart among several
        do_reset(1'b1);
        hart_halt = 4'b0110;
        @(negedge clk);
        check("halt_multi_reason", 64'(stop_reason), 64'd3);
        check("halt_multi_hart", 64'(stop_hart), 64'd1);
        hart_halt = '0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
